// File: rtl/etapa_fetch.sv
// ---------------------------------------------------------------------------
// etapa_fetch -- instruction-fetch stage with IF/ID pipeline register.
//
// The stage fetches one instruction per request from an instruction memory
// with a variable (0..N cycle) acknowledge latency. A hazard unit can stall
// the stage, and a taken branch can flush it and redirect it to a new PC.
//
// Ports
//   clk            in   single clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   proximoPC      in   next PC chosen by the downstream next-PC MUX
//   stall          in   hold PC and IF/ID
//   flush          in   squash wrong-path fetch, redirect to proximoPC
//   imemReq        out  instruction-memory request (high only while fetching)
//   imemAddr       out  fetch address (current PC)
//   imemAck        in   memory returns imemData this cycle
//   imemData       in   fetched instruction word
//   salidaPC       out  current PC register
//   pcMas4         out  salidaPC + 4 (wraps modulo 2^ANCHO)
//   instruccionID  out  IF/ID instruction register
//   pcMas4ID       out  IF/ID PC+4 register
//   validoID       out  IF/ID holds a real instruction (0 = bubble)
// ---------------------------------------------------------------------------
module etapa_fetch #(
    parameter int unsigned      ANCHO    = 32,
    parameter logic [ANCHO-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ANCHO-1:0] proximoPC,
    input  logic             stall,
    input  logic             flush,
    output logic             imemReq,
    output logic [ANCHO-1:0] imemAddr,
    input  logic             imemAck,
    input  logic [ANCHO-1:0] imemData,
    output logic [ANCHO-1:0] salidaPC,
    output logic [ANCHO-1:0] pcMas4,
    output logic [ANCHO-1:0] instruccionID,
    output logic [ANCHO-1:0] pcMas4ID,
    output logic             validoID
);

    localparam logic [ANCHO-1:0] CUATRO = ANCHO'(4);

    typedef enum logic [1:0] {
        INICIO   = 2'd0,
        EMITIR   = 2'd1,
        RETENIDO = 2'd2
    } estado_t;

    estado_t          estado_q, estado_d;

    logic [ANCHO-1:0] pc_q, pc_d;
    logic [ANCHO-1:0] instr_id_q, instr_id_d;
    logic [ANCHO-1:0] pc4_id_q, pc4_id_d;
    logic             valido_id_q, valido_id_d;
    logic [ANCHO-1:0] buf_instr_q, buf_instr_d;
    logic             descartar_q, descartar_d;
    logic [ANCHO-1:0] pc_destino_q, pc_destino_d;

    logic [ANCHO-1:0] pc_mas4;

    // Modulo 2^ANCHO by construction: 0xFFFF_FFFC + 4 wraps to 0.
    assign pc_mas4 = pc_q + CUATRO;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= INICIO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic (flush always wins over stall)
    // -----------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIO: begin
                estado_d = EMITIR;
            end
            EMITIR: begin
                // Only a good (not discarded, not flushed) response that meets
                // a stall has to be parked in bufInstr.
                if (imemAck && !flush && !descartar_q && stall) begin
                    estado_d = RETENIDO;
                end
            end
            RETENIDO: begin
                if (flush || !stall) begin
                    estado_d = EMITIR;
                end
            end
            default: begin
                estado_d = INICIO;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. The request is held for the whole EMITIR state, so the
    // address (PC) cannot change while a request is outstanding.
    // -----------------------------------------------------------------------
    always_comb begin
        imemReq = (estado_q == EMITIR);
    end

    // -----------------------------------------------------------------------
    // Datapath next-state: PC, IF/ID, response buffer and flush bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        logic             burbuja;
        logic             cargar;
        logic [ANCHO-1:0] dato_carga;

        burbuja      = 1'b0;
        cargar       = 1'b0;
        dato_carga   = imemData;

        pc_d         = pc_q;
        instr_id_d   = instr_id_q;
        pc4_id_d     = pc4_id_q;
        valido_id_d  = valido_id_q;
        buf_instr_d  = buf_instr_q;
        descartar_d  = descartar_q;
        pc_destino_d = pc_destino_q;

        case (estado_q)
            EMITIR: begin
                if (!imemAck) begin
                    if (flush) begin
                        // The request cannot be withdrawn; remember that its
                        // data must be dropped and where to go afterwards.
                        descartar_d  = 1'b1;
                        pc_destino_d = proximoPC;
                        burbuja      = 1'b1;
                    end else if (!stall) begin
                        burbuja = 1'b1;
                    end
                end else if (flush) begin
                    pc_d        = proximoPC;
                    descartar_d = 1'b0;
                    burbuja     = 1'b1;
                end else if (descartar_q) begin
                    pc_d        = pc_destino_q;
                    descartar_d = 1'b0;
                    burbuja     = 1'b1;
                end else if (stall) begin
                    buf_instr_d = imemData;
                end else begin
                    cargar = 1'b1;
                    pc_d   = proximoPC;
                end
            end
            RETENIDO: begin
                if (flush) begin
                    pc_d    = proximoPC;
                    burbuja = 1'b1;
                end else if (!stall) begin
                    cargar     = 1'b1;
                    dato_carga = buf_instr_q;
                    pc_d       = proximoPC;
                end
            end
            default: begin
            end
        endcase

        if (burbuja) begin
            instr_id_d  = '0;
            pc4_id_d    = '0;
            valido_id_d = 1'b0;
        end else if (cargar) begin
            instr_id_d  = dato_carga;
            pc4_id_d    = pc_mas4;
            valido_id_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= PC_RESET;
            instr_id_q   <= '0;
            pc4_id_q     <= '0;
            valido_id_q  <= 1'b0;
            buf_instr_q  <= '0;
            descartar_q  <= 1'b0;
            pc_destino_q <= '0;
        end else begin
            pc_q         <= pc_d;
            instr_id_q   <= instr_id_d;
            pc4_id_q     <= pc4_id_d;
            valido_id_q  <= valido_id_d;
            buf_instr_q  <= buf_instr_d;
            descartar_q  <= descartar_d;
            pc_destino_q <= pc_destino_d;
        end
    end

    assign imemAddr      = pc_q;
    assign salidaPC      = pc_q;
    assign pcMas4        = pc_mas4;
    assign instruccionID = instr_id_q;
    assign pcMas4ID      = pc4_id_q;
    assign validoID      = valido_id_q;

endmodule

// File: tb/tb_etapa_fetch.sv
// ---------------------------------------------------------------------------
// tb_etapa_fetch -- randomized scoreboard bench for etapa_fetch.
//
// The bench plays instruction memory (word at address a is mem(a), random
// 0..3 cycle ack latency, occasional spurious acks while no request is up)
// and hazard/branch unit (random stall, flush and jump targets). A
// transaction-level model tracks which address the next surviving fetch must
// come from and pushes the expected {instruction, PC+4} for every response
// that is accepted; a separate monitor pops an entry whenever IF/ID takes a
// new instruction.
// ---------------------------------------------------------------------------
module tb_etapa_fetch;

    localparam int          ANCHO    = 32;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic [31:0] proximoPC;
    logic        stall;
    logic        flush;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] salidaPC;
    logic [31:0] pcMas4;
    logic [31:0] instruccionID;
    logic [31:0] pcMas4ID;
    logic        validoID;

    etapa_fetch #(.ANCHO(ANCHO), .PC_RESET(PC_RESET)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .proximoPC    (proximoPC),
        .stall        (stall),
        .flush        (flush),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemAck      (imemAck),
        .imemData     (imemData),
        .salidaPC     (salidaPC),
        .pcMas4       (pcMas4),
        .instruccionID(instruccionID),
        .pcMas4ID     (pcMas4ID),
        .validoID     (validoID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t      sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model state
    logic [31:0] exp_fetch;   // address the next surviving fetch must use
    bit          squashed;    // outstanding request was flushed; drop its data
    bit          held;        // last accepted response is parked (not in IF/ID yet)
    bit          skip_edge;   // next edge is the start-up cycle after reset

    // Driver bookkeeping
    int          wait_left = -1;
    bit          req_s;
    logic [31:0] addr_s;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFFC;
        else t = 32'($urandom_range(0, 255)) << 2;
        return t;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applied at the rising edge, before the DUT registers update, using the
    // inputs the bench has been holding for the cycle that just ended.
    task automatic model_edge();
        bit     ack_e;
        entry_t e;
        if (!reset_n) return;
        if (skip_edge) begin
            skip_edge = 1'b0;
            return;
        end
        ack_e = imemAck && req_s;
        if (flush) begin
            if (held) begin
                void'(sb_q.pop_back());
                held = 1'b0;
            end
            squashed  = req_s && !ack_e;
            exp_fetch = proximoPC;
        end else if (ack_e) begin
            if (squashed) begin
                squashed = 1'b0;
            end else begin
                check32("fetch_addr", addr_s, exp_fetch);
                e.instr = mem(addr_s);
                e.pc4   = addr_s + 32'd4;
                sb_q.push_back(e);
                if (stall) held = 1'b1;
                else exp_fetch = proximoPC;
            end
        end else if (held && !stall) begin
            held      = 1'b0;
            exp_fetch = proximoPC;
        end
    endtask

    // Chooses the inputs for the coming cycle (called just after an edge).
    task automatic drive_cycle(input bit rnd);
        req_s    = imemReq;
        addr_s   = imemAddr;
        stall    = 1'b0;
        flush    = 1'b0;
        imemAck  = 1'b0;
        imemData = $urandom;
        if (req_s) begin
            if (wait_left < 0) wait_left = rnd ? int'($urandom_range(0, 3)) : 0;
            if (wait_left == 0) begin
                imemAck   = 1'b1;
                imemData  = mem(addr_s);
                wait_left = -1;
            end else begin
                wait_left--;
            end
        end else if (rnd && $urandom_range(0, 3) == 0) begin
            imemAck = 1'b1;
        end
        if (rnd && !skip_edge) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
        end
        proximoPC = exp_fetch + 32'd4;
        if (flush || (rnd && $urandom_range(0, 9) == 0)) proximoPC = pick_target();
    endtask

    task automatic step(input bit rnd);
        @(posedge clk);
        model_edge();
        #1;
        drive_cycle(rnd);
    endtask

    task automatic release_reset(input bit rnd);
        reset_n   = 1'b1;
        skip_edge = 1'b1;
        wait_left = -1;
        drive_cycle(rnd);
        @(negedge clk);
        check32("inicio_imemReq", 32'(imemReq), 32'd0);
        step(rnd);
        @(negedge clk);
        check32("first_imemReq", 32'(imemReq), 32'd1);
        check32("first_imemAddr", imemAddr, PC_RESET);
    endtask

    task automatic model_reset();
        sb_q.delete();
        exp_fetch = PC_RESET;
        squashed  = 1'b0;
        held      = 1'b0;
    endtask

    // Driver / sequencer
    initial begin
        reset_n   = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        imemAck   = 1'b0;
        imemData  = '0;
        proximoPC = '0;
        skip_edge = 1'b0;
        model_reset();

        #1;
        check32("rst_salidaPC", salidaPC, PC_RESET);
        check32("rst_imemReq", 32'(imemReq), 32'd0);
        check32("rst_validoID", 32'(validoID), 32'd0);
        check32("rst_instrID", instruccionID, 32'd0);
        check32("rst_pcMas4ID", pcMas4ID, 32'd0);
        check32("rst_pcMas4", pcMas4, PC_RESET + 32'd4);

        repeat (2) @(posedge clk);
        #1;
        release_reset(1'b0);

        // Zero-latency memory, no hazards: one instruction per cycle.
        repeat (20) step(1'b0);

        repeat (1500) step(1'b1);

        // Asynchronous reset while a request waits for its ack.
        for (int i = 0; i < 100; i++) begin
            step(1'b1);
            if (req_s && !imemAck) break;
        end
        check32("pre_reset_imemReq", 32'(imemReq), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check32("arst_salidaPC", salidaPC, PC_RESET);
        check32("arst_imemReq", 32'(imemReq), 32'd0);
        check32("arst_validoID", 32'(validoID), 32'd0);
        check32("arst_pcMas4", pcMas4, PC_RESET + 32'd4);
        model_reset();
        stall   = 1'b0;
        flush   = 1'b0;
        imemAck = 1'b0;
        @(posedge clk);
        #1;
        release_reset(1'b1);

        repeat (1500) step(1'b1);

        // Drain: no hazards, zero latency, every accepted word must retire.
        repeat (30) step(1'b0);
        @(negedge clk);
        check32("drain_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Monitor
    bit          st_e;
    bit          fl_e;
    bit          rst_e;
    logic [31:0] prev_i;
    logic [31:0] prev_p;
    logic        prev_v;

    initial begin
        entry_t e;
        prev_i = '0;
        prev_p = '0;
        prev_v = 1'b0;
        forever begin
            @(posedge clk);
            st_e  = stall;
            fl_e  = flush;
            rst_e = reset_n;
            @(negedge clk);
            if (rst_e && reset_n) begin
                check32("pcMas4", pcMas4, salidaPC + 32'd4);
                if (salidaPC == 32'hFFFF_FFFC) check32("pc_wrap", pcMas4, 32'h0000_0000);
                if (imemReq && !squashed) check32("imemAddr", imemAddr, exp_fetch);
                if (!validoID) begin
                    check32("bubble_instr", instruccionID, 32'd0);
                    check32("bubble_pc4", pcMas4ID, 32'd0);
                end
                if (st_e && !fl_e) begin
                    check32("hold_instr", instruccionID, prev_i);
                    check32("hold_pc4", pcMas4ID, prev_p);
                    check32("hold_valid", 32'(validoID), 32'(prev_v));
                end
                if (validoID && !st_e) begin
                    n_tests++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_instr: got %h/%h expected none", instruccionID, pcMas4ID);
                    end else begin
                        n_tests--;
                        e = sb_q.pop_front();
                        check32("ifid_instr", instruccionID, e.instr);
                        check32("ifid_pc4", pcMas4ID, e.pc4);
                    end
                end
            end
            prev_i = instruccionID;
            prev_p = pcMas4ID;
            prev_v = validoID;
        end
    end

endmodule
